// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner of a shared tristate bus with z turnaround and hold limit
module tristate_bus_arbiter #(
  parameter int WIDTH      = 8,
  parameter int N          = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic [N*WIDTH-1:0]     din,
  output logic [N-1:0]           gnt,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   bus_oe,
  inout  wire  [WIDTH-1:0]       bus,
  output logic [WIDTH-1:0]       bus_in,
  output logic                   hold_expired
);

  localparam int OW = $clog2(N);
  localparam int TW = $clog2(TURNAROUND + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, TURN, DRIVE} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   ptr, winner, sel;
  logic            found;
  logic [TW-1:0]   tcnt;
  logic [HW-1:0]   hold;
  logic [N-1:0]    gnt_nxt;
  logic            oe_nxt, exp_nxt;
  logic [WIDTH-1:0] drive;

  // round-robin pick: first requesting channel at or above ptr, wrapping
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sel = OW'((int'(ptr) + k) % N);
      if (req[sel]) begin
        winner = sel;
        found  = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // next state; a request drop always wins over hold expiry
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = found ? TURN : IDLE;
      TURN:    state_nxt = !req[owner] ? IDLE : (tcnt == TW'(1) ? DRIVE : TURN);
      DRIVE:   state_nxt = (!req[owner] || hold == HW'(MAX_HOLD)) ? IDLE : DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  // next registered outputs: grant follows the state we are about to enter
  always_comb begin
    gnt_nxt = (state_nxt == DRIVE) ? (N'(1) << owner) : '0;
    oe_nxt  = state_nxt == DRIVE;
    exp_nxt = state == DRIVE && req[owner] && hold == HW'(MAX_HOLD);
  end

  // owner, pointer, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt          <= '0;
      bus_oe       <= 1'b0;
      hold_expired <= 1'b0;
      owner        <= '0;
      ptr          <= '0;
      tcnt         <= '0;
      hold         <= '0;
    end else begin
      gnt          <= gnt_nxt;
      bus_oe       <= oe_nxt;
      hold_expired <= exp_nxt;
      if (state == IDLE && found) begin
        owner <= winner;
        tcnt  <= TW'(TURNAROUND);
      end
      if (state == TURN) tcnt <= tcnt - 1'b1;
      if (state == TURN && state_nxt == DRIVE) begin
        ptr  <= (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
        hold <= HW'(1);
      end else if (state == DRIVE && state_nxt == DRIVE) hold <= hold + 1'b1;
    end

  // per-channel gating of drive data by its grant bit
  always_comb begin
    drive = '0;
    for (int i = 0; i < N; i++) drive = drive | (gnt[i] ? din[i*WIDTH +: WIDTH] : '0);
  end

  assign bus    = bus_oe ? drive : 'z;
  assign bus_in = bus;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: vector table plus directed multi-cycle sequences for the bus arbiter
module tb_tristate_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [3:0]  ra, rb;
  logic [31:0] da, db;
  logic [3:0]  ga, gb;
  logic [1:0]  oa, ob;
  logic        oea, oeb, hea, heb;
  wire  [7:0]  busa, busb;
  logic [7:0]  bina, binb;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign da = {8'h43, 8'h32, 8'hA5, 8'h10};
  assign db = {8'h7E, 8'h5C, 8'h21, 8'h0F};

  tristate_bus_arbiter #(.WIDTH(8), .N(4), .TURNAROUND(1), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .req(ra), .din(da), .gnt(ga), .owner(oa),
    .bus_oe(oea), .bus(busa), .bus_in(bina), .hold_expired(hea)
  );

  tristate_bus_arbiter #(.WIDTH(8), .N(4), .TURNAROUND(3), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_b), .req(rb), .din(db), .gnt(gb), .owner(ob),
    .bus_oe(oeb), .bus(busb), .bus_in(binb), .hold_expired(heb)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       oe;
    logic [1:0] owner;
    logic       he;
    logic [7:0] bus;
  } vec_t;

  vec_t tv[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_a(input int budget);
    int n = 0;
    while (ga == 4'b0 && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc;
    tv[0]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[1]  = '{4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0, 8'h00};
    tv[2]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0, 8'hA5};
    tv[3]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0, 8'hA5};
    tv[4]  = '{4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 8'h00};
    tv[5]  = '{4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 8'h00};
    tv[6]  = '{4'b1111, 4'b0000, 1'b0, 2'd2, 1'b0, 8'h00};
    tv[7]  = '{4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0, 8'h32};
    tv[8]  = '{4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0, 8'h32};
    tv[9]  = '{4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0, 8'h32};
    tv[10] = '{4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0, 8'h32};
    tv[11] = '{4'b1111, 4'b0000, 1'b0, 2'd2, 1'b1, 8'h00};
    tv[12] = '{4'b1111, 4'b0000, 1'b0, 2'd3, 1'b0, 8'h00};
    tv[13] = '{4'b1111, 4'b1000, 1'b1, 2'd3, 1'b0, 8'h43};
    tv[14] = '{4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0, 8'h00};

    rst_a = 1'b0;
    rst_b = 1'b0;
    ra = '0;
    rb = '0;
    step();
    step();
    chk("reset_gnt", ga, 4'b0);
    chk("reset_oe", oea, 1'b0);
    chk("reset_owner", oa, 2'd0);
    chk("reset_he", hea, 1'b0);
    chk("reset_b_oe", oeb, 1'b0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    for (int i = 0; i < 15; i++) begin
      ra = tv[i].req;
      step();
      chk($sformatf("v%0d_gnt", i), ga, tv[i].gnt);
      chk($sformatf("v%0d_oe", i), oea, tv[i].oe);
      chk($sformatf("v%0d_owner", i), oa, tv[i].owner);
      chk($sformatf("v%0d_he", i), hea, tv[i].he);
      chk($sformatf("v%0d_onehot", i), $onehot0(ga), 1'b1);
      if (tv[i].oe) begin
        chk($sformatf("v%0d_bus", i), busa, tv[i].bus);
        chk($sformatf("v%0d_bus_in", i), bina, tv[i].bus);
      end
    end

    ra = 4'b0001;
    wait_a(8);
    chk("hold_first_gnt", ga, 4'b0001);
    chk("hold_first_bus", busa, 8'h10);
    dc = 1;
    for (int n = 0; n < 10 && ga == 4'b0001; n++) begin
      step();
      if (ga == 4'b0001) dc++;
    end
    chk("hold_drive_cycles", dc, 4);
    chk("hold_expired_pulse", hea, 1'b1);
    chk("hold_release_oe", oea, 1'b0);
    step();
    chk("hold_pulse_single", hea, 1'b0);
    chk("hold_z_gap", ga, 4'b0);
    step();
    chk("hold_regrant_ch0", ga, 4'b0001);
    ra = 4'b0011;
    repeat (3) step();
    chk("hold2_still_ch0", ga, 4'b0001);
    step();
    chk("hold2_expired", hea, 1'b1);
    chk("hold2_release", ga, 4'b0);
    step();
    chk("hold2_turn_z", oea, 1'b0);
    chk("hold2_owner_ch1", oa, 2'd1);
    step();
    chk("hold2_next_ch1", ga, 4'b0010);
    chk("hold2_bus_ch1", busa, 8'hA5);

    ra = 4'b0000;
    step();
    chk("drop_release", ga, 4'b0);
    step();

    ra = 4'b0100;
    wait_a(8);
    chk("sim_gnt_ch2", ga, 4'b0100);
    repeat (3) step();
    chk("sim_last_hold", ga, 4'b0100);
    ra = 4'b0000;
    step();
    chk("sim_release_gnt", ga, 4'b0);
    chk("sim_no_expire", hea, 1'b0);
    step();
    chk("sim_no_expire_late", hea, 1'b0);

    rb = 4'b0100;
    step();
    step();
    rb = 4'b0000;
    for (int n = 0; n < 6; n++) begin
      step();
      chk($sformatf("abort_gnt_%0d", n), gb, 4'b0);
      chk($sformatf("abort_oe_%0d", n), oeb, 1'b0);
    end
    rb = 4'b1100;
    repeat (3) step();
    chk("abort_turn_gnt", gb, 4'b0);
    step();
    chk("abort_next_ch2", gb, 4'b0100);
    chk("abort_bus_ch2", busb, 8'h5C);
    rb = 4'b0000;

    ra = 4'b0001;
    wait_a(8);
    chk("rst_mid_gnt_before", ga, 4'b0001);
    #2 rst_a = 1'b0;
    #1;
    chk("rst_mid_gnt", ga, 4'b0);
    chk("rst_mid_oe", oea, 1'b0);
    step();
    ra = 4'b0000;
    rst_a = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      chk($sformatf("idle_oe_%0d", n), oea, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
